// File: rtl/parity_serial_tx.sv
// Serial frame transmitter with generated parity bit. Frame on s: start (0),
// WIDTH data bits LSB first, parity, stop (1); the line idles high.
module parity_serial_tx #(
  parameter int WIDTH      = 8,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  output logic             s,
  output logic             busy,
  output logic             done
);

  localparam int             CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q,  sreg_d;
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             par_q,   par_d;
  logic             s_d, busy_d, done_d;

  // The output registers are loaded with the value belonging to the state
  // being entered, so s/busy/done change on the same edge as the state and
  // there is no combinational path from start or data to any output.
  always_comb begin
    // NOTE: every signal gets a default first so no path through the case
    // leaves one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    par_d   = par_q;
    s_d     = 1'b1;
    busy_d  = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          sreg_d  = data;
          cnt_d   = '0;
          par_d   = PARITY_ODD;
          s_d     = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        // Bit 0 goes onto the line and into the parity as DATA is entered.
        state_d = DATA;
        s_d     = sreg_q[0];
        sreg_d  = sreg_q >> 1;
        par_d   = par_q ^ sreg_q[0];
        busy_d  = 1'b1;
      end

      DATA: begin
        busy_d = 1'b1;
        if (cnt_q == LAST) begin
          state_d = PARITY;
          s_d     = par_q;
        end else begin
          s_d    = sreg_q[0];
          sreg_d = sreg_q >> 1;
          par_d  = par_q ^ sreg_q[0];
          cnt_d  = cnt_q + CW'(1);
        end
      end

      PARITY: begin
        state_d = STOP;
        busy_d  = 1'b1;
        done_d  = 1'b1;
      end

      STOP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the shift register is reset along with the control state; it
      // is a single word of flops, not a memory array, so the cost is small
      // and a post-reset dump of the datapath is deterministic.
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      par_q   <= 1'b0;
      s       <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      s       <= s_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_parity_serial_tx.sv
// Self-checking bench for parity_serial_tx: an even and an odd instance share
// stimulus and are compared cycle by cycle against a queue-built frame model.
module tb_parity_serial_tx;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] data  = 8'h00;
  logic       s_e, busy_e, done_e;
  logic       s_o, busy_o, done_o;

  int n_pass  = 0;
  int n_total = 0;

  parity_serial_tx #(.WIDTH(8), .PARITY_ODD(1'b0)) dut_even (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .s(s_e), .busy(busy_e), .done(done_e)
  );

  parity_serial_tx #(.WIDTH(8), .PARITY_ODD(1'b1)) dut_odd (
    .clk(clk), .reset(reset), .start(start), .data(data),
    .s(s_o), .busy(busy_o), .done(done_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0]  d;
    logic [10:0] frame_even;  // bit k = s during cycle k of the frame
    logic        p_odd;
  } vec_t;

  vec_t tbl[6];

  task automatic check1(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    else
      n_pass++;
  endtask

  task automatic check11(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    else
      n_pass++;
  endtask

  task automatic check_idle(input string name);
    check1({name, "_s_even"},    s_e,    1'b1);
    check1({name, "_busy_even"}, busy_e, 1'b0);
    check1({name, "_done_even"}, done_e, 1'b0);
    check1({name, "_s_odd"},     s_o,    1'b1);
    check1({name, "_busy_odd"},  busy_o, 1'b0);
    check1({name, "_done_odd"},  done_o, 1'b0);
  endtask

  // Frame as a bit list: start, data LSB first, parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input bit odd);
    bit          q[$];
    logic [10:0] f;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
    q.push_back(bit'(($countones(d) + int'(odd)) % 2));
    q.push_back(1'b1);
    for (int k = 0; k < 11; k++) f[k] = q[k];
    return f;
  endfunction

  // Entered #1 after the accept edge; leaves #1 after the STOP-cycle edge.
  task automatic check_frame(input logic [7:0] d, input bit abuse,
                             output logic [10:0] fe, output logic [10:0] fo);
    logic [10:0] me, mo;
    me = model_frame(d, 1'b0);
    mo = model_frame(d, 1'b1);
    for (int k = 0; k < 11; k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      fe[k] = s_e;
      fo[k] = s_o;
      check1("frame_s_even",    s_e,    me[k]);
      check1("frame_s_odd",     s_o,    mo[k]);
      check1("frame_busy_even", busy_e, 1'b1);
      check1("frame_busy_odd",  busy_o, 1'b1);
      check1("frame_done_even", done_e, k == 10);
      check1("frame_done_odd",  done_o, k == 10);
      // Mid-frame disturbance during DATA bit 3: new data plus a start pulse.
      if (abuse && k == 4) begin
        data  = ~d;
        start = 1'b1;
      end
      if (abuse && k == 5) start = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] d, input bit abuse,
                      output logic [10:0] fe, output logic [10:0] fo);
    @(posedge clk);
    #1;
    check_idle("pre_idle");
    data  = d;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_frame(d, abuse, fe, fo);
  endtask

  initial begin
    logic [10:0] fe, fo;
    logic [7:0]  bb[4];

    tbl[0] = '{8'hA5, 11'b10101001010, 1'b1};
    tbl[1] = '{8'h07, 11'b11000001110, 1'b0};
    tbl[2] = '{8'hFF, 11'b10111111110, 1'b1};
    tbl[3] = '{8'h00, 11'b10000000000, 1'b1};
    tbl[4] = '{8'h01, 11'b11000000010, 1'b0};
    tbl[5] = '{8'h80, 11'b11100000000, 1'b0};

    // Reset held two cycles, then quiet idle line.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_idle("in_reset");
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_idle("reset_idle");
    end

    // Directed vectors with hand-derived frames and odd-mode parity bits.
    for (int i = 0; i < 6; i++) begin
      send(tbl[i].d, 1'b0, fe, fo);
      check11("tbl_frame_even", fe, tbl[i].frame_even);
      check1("tbl_par_odd", fo[9], tbl[i].p_odd);
    end

    // Start and data changes mid-frame are ignored and not queued.
    send(8'h3C, 1'b1, fe, fo);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      check_idle("no_queued_frame");
    end

    // start held high: back-to-back frames, one idle cycle between them.
    for (int i = 0; i < 4; i++) bb[i] = 8'($urandom);
    data  = bb[0];
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int f = 0; f < 4; f++) begin
      if (f < 3) data = bb[f + 1];
      else       start = 1'b0;
      check_frame(bb[f], 1'b0, fe, fo);
      @(posedge clk);
      #1;
      check_idle("b2b_gap");
      if (f < 3) begin
        @(posedge clk);
        #1;
      end
    end

    // Random words with random idle gaps.
    for (int n = 0; n < 20; n++) begin
      int gap;
      gap = int'($urandom_range(0, 3));
      repeat (gap) begin
        @(posedge clk);
        #1;
        check_idle("rand_gap");
      end
      send(8'($urandom), 1'b0, fe, fo);
    end

    // Asynchronous reset between edges during DATA bit 4.
    @(posedge clk);
    #1;
    check_idle("pre_abort");
    data  = 8'h96;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_idle("async_reset");
    start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_idle("reset_beats_start");
    end
    start = 1'b0;
    #2;
    reset = 1'b0;
    send(8'h5A, 1'b0, fe, fo);
    check11("post_reset_frame_even", fe, 11'b10010110100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
